// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture_ctrl
// Brief    : Captures a 2-byte-per-pixel camera stream and decimates it by 2^S in x and y before it is written to memory.
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture_ctrl #(
    parameter int SRC_W       = 640,
    parameter int SRC_H       = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        data,
    input  logic              cap_en,
    input  logic              single_shot,
    input  logic              byte_swap,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_short,
    output logic              sync_err
);

    localparam int c_X_W = $clog2(SRC_W + 1);
    localparam int c_Y_W = $clog2(SRC_H + 1);
    localparam int c_DEC = 1 << SCALE_SHIFT;
    localparam logic [c_X_W-1:0]  c_X_LIM    = c_X_W'(SRC_W);
    localparam logic [c_Y_W-1:0]  c_Y_LIM    = c_Y_W'(SRC_H);
    localparam logic [c_X_W-1:0]  c_X_MASK   = c_X_W'(c_DEC - 1);
    localparam logic [c_Y_W-1:0]  c_Y_MASK   = c_Y_W'(c_DEC - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX =
        ADDR_W'((SRC_W >> SCALE_SHIFT) * (SRC_H >> SCALE_SHIFT) - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_vsync_q;
    logic              r_href_q;
    logic              r_phase;
    logic [7:0]        r_byte0;
    logic [c_X_W-1:0]  r_x;
    logic [c_Y_W-1:0]  r_y;
    logic [ADDR_W-1:0] r_addr;

    logic              w_vsync_fall;
    logic              w_vsync_rise;
    logic              w_href_fall;
    logic              w_x_in;
    logic              w_y_in;
    logic              w_on_grid;
    logic              w_store;
    logic [c_Y_W-1:0]  w_y_end;
    logic [15:0]       w_pixel;

    assign w_vsync_fall = r_vsync_q & ~vsync;
    assign w_vsync_rise = ~r_vsync_q & vsync;
    assign w_href_fall  = r_href_q & ~href;
    assign w_x_in       = (r_x < c_X_LIM);
    assign w_y_in       = (r_y < c_Y_LIM);
    assign w_on_grid    = ((r_x & c_X_MASK) == '0) && ((r_y & c_Y_MASK) == '0);
    assign w_store      = href & r_phase & w_x_in & w_y_in & w_on_grid;
    // Line counter saturates at SRC_H so surplus lines stay dropped without wrapping.
    assign w_y_end      = (w_href_fall && w_y_in) ? r_y + 1'b1 : r_y;
    assign w_pixel      = byte_swap ? {data, r_byte0} : {r_byte0, data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_vsync_q   <= 1'b0;
            r_href_q    <= 1'b0;
            r_phase     <= 1'b0;
            r_byte0     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= '0;
            we          <= 1'b0;
            wAddr       <= '0;
            wData       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_short <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            r_vsync_q <= vsync;
            r_href_q  <= href;
            we        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cap_en) begin
                        r_state  <= WAIT_SOF;
                        busy     <= 1'b1;
                        sync_err <= 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (w_vsync_fall) begin
                        r_state <= ACTIVE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_phase <= 1'b0;
                        r_addr  <= '0;
                        wAddr   <= '0;
                    end
                end
                ACTIVE: begin
                    if (href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_byte0 <= data;
                        end else begin
                            if (w_x_in) begin
                                r_x <= r_x + 1'b1;
                            end else begin
                                sync_err <= 1'b1;
                            end
                            if (w_store) begin
                                we    <= 1'b1;
                                wAddr <= r_addr;
                                wData <= w_pixel;
                                if (r_addr != c_ADDR_MAX) begin
                                    r_addr <= r_addr + 1'b1;
                                end
                            end
                        end
                    end else if (w_href_fall) begin
                        r_y     <= w_y_end;
                        r_x     <= '0;
                        r_phase <= 1'b0;
                        if (r_phase) begin
                            sync_err <= 1'b1;
                        end
                    end
                    if (w_vsync_rise) begin
                        r_state     <= DONE;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_short <= (w_y_end < c_Y_LIM);
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    // Dropping cap_en mid-frame lets the frame finish, then parks in IDLE.
                    if (single_shot || !cap_en) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= WAIT_SOF;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_capture_ctrl
// Brief    : Self-checking bench for cam_capture_ctrl; two instances (4x2 S=0, 4x4 S=1) are compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        href = 1'b0;
    logic        vsync = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        cap_en = 1'b0;
    logic        single_shot = 1'b1;
    logic        byte_swap = 1'b0;

    logic        we0, busy0, fd0, fs0, se0;
    logic [16:0] wa0;
    logic [15:0] wd0;
    logic        we1, busy1, fd1, fs1, se1;
    logic [16:0] wa1;
    logic [15:0] wd1;

    always #5 clk = ~clk;

    cam_capture_ctrl #(.SRC_W(4), .SRC_H(2), .SCALE_SHIFT(0), .ADDR_W(17)) dut0 (
        .clk(clk), .reset(reset), .href(href), .vsync(vsync), .data(data),
        .cap_en(cap_en), .single_shot(single_shot), .byte_swap(byte_swap),
        .we(we0), .wAddr(wa0), .wData(wd0), .busy(busy0),
        .frame_done(fd0), .frame_short(fs0), .sync_err(se0)
    );

    cam_capture_ctrl #(.SRC_W(4), .SRC_H(4), .SCALE_SHIFT(1), .ADDR_W(17)) dut1 (
        .clk(clk), .reset(reset), .href(href), .vsync(vsync), .data(data),
        .cap_en(cap_en), .single_shot(single_shot), .byte_swap(byte_swap),
        .we(we1), .wAddr(wa1), .wData(wd1), .busy(busy1),
        .frame_done(fd1), .frame_short(fs1), .sync_err(se1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory writes and frame completions
    int   g0_addr[$], g0_data[$], g0_cyc[$];
    int   g1_addr[$], g1_data[$], g1_cyc[$];
    int   g0_done = 0, g1_done = 0;
    logic g0_short = 1'b0, g1_short = 1'b0;

    always @(negedge clk) begin
        if (we0) begin
            g0_addr.push_back(int'(wa0)); g0_data.push_back(int'(wd0)); g0_cyc.push_back(cyc);
        end
        if (we1) begin
            g1_addr.push_back(int'(wa1)); g1_data.push_back(int'(wd1)); g1_cyc.push_back(cyc);
        end
        if (fd0) begin g0_done++; g0_short = fs0; end
        if (fd1) begin g1_done++; g1_short = fs1; end
    end

    int vecs = 0;
    int errs = 0;

    // Bytes driven in the current frame, with line, position and sampling cycle
    int fb_data[$], fb_line[$], fb_pos[$], fb_cyc[$];
    int line_len[8];
    int n_lines;

    int exp_addr[$], exp_data[$], exp_cyc[$];
    bit exp_err, exp_short;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic start_capture(input bit ss);
        vsync = 1'b1; single_shot = ss; cap_en = 1'b1;
        tick;
        if (ss) cap_en = 1'b0;
        tick;
    endtask

    // mode 0 = random bytes, 1 = incrementing bytes, 2 = AA,55 then random
    task automatic drive_frame(input int mode);
        int v;
        v = 0;
        fb_data.delete(); fb_line.delete(); fb_pos.delete(); fb_cyc.delete();
        vsync = 1'b0;
        tick; tick; tick;
        for (int l = 0; l < n_lines; l++) begin
            for (int p = 0; p < line_len[l]; p++) begin
                href = 1'b1;
                if (mode == 1)                 data = 8'(v);
                else if (mode == 2 && v == 0)  data = 8'hAA;
                else if (mode == 2 && v == 1)  data = 8'h55;
                else                           data = 8'($urandom);
                v++;
                fb_data.push_back(int'(data)); fb_line.push_back(l);
                fb_pos.push_back(p);           fb_cyc.push_back(cyc + 1);
                tick;
            end
            href = 1'b0; data = 8'h00;
            repeat (3) tick;
        end
        vsync = 1'b1;
        repeat (6) tick;
    endtask

    // Reference: pixel (x,y) = bytes 2x,2x+1 of line y; kept if on the 2^s grid and in range.
    task automatic build_expected(input int w, input int h, input int s);
        int d, k, x, y;
        d = 1 << s;
        k = 0;
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        exp_err = 1'b0;
        exp_short = (n_lines < h);
        for (int l = 0; l < n_lines; l++) if (line_len[l] % 2 == 1) exp_err = 1'b1;
        for (int i = 0; i < fb_data.size(); i++) begin
            if (fb_pos[i] % 2 == 1) begin
                x = fb_pos[i] / 2;
                y = fb_line[i];
                if (x >= w) exp_err = 1'b1;
                else if (y < h && x % d == 0 && y % d == 0) begin
                    exp_addr.push_back(k);
                    exp_data.push_back(byte_swap ? (fb_data[i] << 8) | fb_data[i-1]
                                                 : (fb_data[i-1] << 8) | fb_data[i]);
                    exp_cyc.push_back(fb_cyc[i]);
                    k++;
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [36:0] o;
        reset = 1'b1;
        repeat (3) tick;
        o = {we0, wa0, wd0, busy0, fd0, fs0, se0};
        vecs++;
        if (o !== '0) begin errs++; $display("FAIL reset_outputs_dut0: got %h want 0", o); end
        reset = 1'b0;
        tick;
        o = {we1, wa1, wd1, busy1, fd1, fs1, se1};
        vecs++;
        if (o !== '0) begin errs++; $display("FAIL reset_outputs_dut1: got %h want 0", o); end
        vecs++;
        if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_idle_busy: got %b want 0", busy0); end
    endtask

    task automatic test_full_frame;
        int b0, d0;
        byte_swap = 1'b0; n_lines = 2; line_len[0] = 8; line_len[1] = 8;
        b0 = g0_addr.size(); d0 = g0_done;
        start_capture(1'b1);
        vecs++;
        if (busy0 !== 1'b1) begin errs++; $display("FAIL full_busy_high: got %b want 1", busy0); end
        drive_frame(1);
        build_expected(4, 2, 0);
        vecs++;
        if (g0_addr.size() - b0 != exp_addr.size()) begin
            errs++; $display("FAIL full_write_count: got %0d want %0d", g0_addr.size() - b0, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && b0 + i < g0_addr.size(); i++) begin
            vecs++;
            if (g0_addr[b0+i] !== exp_addr[i] || g0_data[b0+i] !== exp_data[i] || g0_cyc[b0+i] !== exp_cyc[i]) begin
                errs++;
                $display("FAIL full_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                         g0_addr[b0+i], g0_data[b0+i], g0_cyc[b0+i], exp_addr[i], exp_data[i], exp_cyc[i]);
            end
        end
        vecs++;
        if (g0_addr.size() > b0 && g0_data[b0] !== 16'h0001) begin
            errs++; $display("FAIL full_first_data: got %h want 0001", g0_data[b0]);
        end
        vecs++;
        if (g0_done - d0 !== 1 || g0_short !== 1'b0) begin
            errs++; $display("FAIL full_frame_done: got n=%0d short=%b want n=1 short=0", g0_done - d0, g0_short);
        end
        vecs++;
        if (busy0 !== 1'b0 || se0 !== 1'b0) begin
            errs++; $display("FAIL full_end_state: got busy=%b err=%b want 0 0", busy0, se0);
        end
        vsync = 1'b0; repeat (3) tick; vsync = 1'b1; repeat (2) tick;
        vecs++;
        if (busy0 !== 1'b0) begin errs++; $display("FAIL full_stays_idle: got busy=%b want 0", busy0); end
    endtask

    task automatic test_scale;
        int b1;
        byte_swap = 1'b0; n_lines = 4;
        for (int l = 0; l < 4; l++) line_len[l] = 8;
        b1 = g1_addr.size();
        start_capture(1'b1);
        drive_frame(0);
        build_expected(4, 4, 1);
        vecs++;
        if (g1_addr.size() - b1 != 4) begin
            errs++; $display("FAIL scale_write_count: got %0d want 4", g1_addr.size() - b1);
        end
        for (int i = 0; i < exp_addr.size() && b1 + i < g1_addr.size(); i++) begin
            vecs++;
            if (g1_addr[b1+i] !== exp_addr[i] || g1_data[b1+i] !== exp_data[i] || g1_cyc[b1+i] !== exp_cyc[i]) begin
                errs++;
                $display("FAIL scale_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                         g1_addr[b1+i], g1_data[b1+i], g1_cyc[b1+i], exp_addr[i], exp_data[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_swap;
        int b0;
        byte_swap = 1'b1; n_lines = 2; line_len[0] = 8; line_len[1] = 8;
        b0 = g0_addr.size();
        start_capture(1'b1);
        drive_frame(2);
        build_expected(4, 2, 0);
        vecs++;
        if (g0_addr.size() - b0 != exp_addr.size() || g0_data[b0] !== 16'h55AA) begin
            errs++; $display("FAIL swap_first: got n=%0d d=%h want n=%0d d=55aa",
                             g0_addr.size() - b0, g0_data[b0], exp_addr.size());
        end
        for (int i = 1; i < exp_addr.size() && b0 + i < g0_addr.size(); i++) begin
            vecs++;
            if (g0_data[b0+i] !== exp_data[i]) begin
                errs++; $display("FAIL swap_data[%0d]: got %h want %h", i, g0_data[b0+i], exp_data[i]);
            end
        end
        byte_swap = 1'b0;
    endtask

    task automatic test_sync_err;
        int b0;
        byte_swap = 1'b0; n_lines = 2; line_len[0] = 7; line_len[1] = 8;
        b0 = g0_addr.size();
        start_capture(1'b1);
        drive_frame(0);
        build_expected(4, 2, 0);
        vecs++;
        if (g0_addr.size() - b0 != exp_addr.size()) begin
            errs++; $display("FAIL odd_write_count: got %0d want %0d", g0_addr.size() - b0, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && b0 + i < g0_addr.size(); i++) begin
            vecs++;
            if (g0_addr[b0+i] !== exp_addr[i] || g0_data[b0+i] !== exp_data[i]) begin
                errs++; $display("FAIL odd_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i,
                                 g0_addr[b0+i], g0_data[b0+i], exp_addr[i], exp_data[i]);
            end
        end
        repeat (4) tick;
        vecs++;
        if (se0 !== 1'b1) begin errs++; $display("FAIL odd_sticky: got %b want 1", se0); end
        start_capture(1'b1);
        vecs++;
        if (se0 !== 1'b0) begin errs++; $display("FAIL err_clear_on_start: got %b want 0", se0); end
        line_len[0] = 8;
        drive_frame(0);
    endtask

    task automatic test_short_frame;
        int b0, d0;
        byte_swap = 1'b0; n_lines = 1; line_len[0] = 8;
        b0 = g0_addr.size(); d0 = g0_done;
        start_capture(1'b0);
        drive_frame(0);
        build_expected(4, 2, 0);
        vecs++;
        if (g0_done - d0 !== 1 || g0_short !== exp_short || g0_addr.size() - b0 != exp_addr.size()) begin
            errs++; $display("FAIL short_frame: got n=%0d short=%b w=%0d want n=1 short=%b w=%0d",
                             g0_done - d0, g0_short, g0_addr.size() - b0, exp_short, exp_addr.size());
        end
        vecs++;
        if (busy0 !== 1'b1) begin errs++; $display("FAIL continuous_rearm: got busy=%b want 1", busy0); end
        cap_en = 1'b0; n_lines = 2; line_len[1] = 8;
        b0 = g0_addr.size(); d0 = g0_done;
        drive_frame(0);
        build_expected(4, 2, 0);
        vecs++;
        if (g0_addr.size() - b0 != exp_addr.size()) begin
            errs++; $display("FAIL restart_count: got %0d want %0d", g0_addr.size() - b0, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && b0 + i < g0_addr.size(); i++) begin
            vecs++;
            if (g0_addr[b0+i] !== exp_addr[i] || g0_data[b0+i] !== exp_data[i] || g0_cyc[b0+i] !== exp_cyc[i]) begin
                errs++; $display("FAIL restart_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                                 g0_addr[b0+i], g0_data[b0+i], g0_cyc[b0+i], exp_addr[i], exp_data[i], exp_cyc[i]);
            end
        end
        vecs++;
        if (g0_done - d0 !== 1 || g0_short !== 1'b0 || busy0 !== 1'b0) begin
            errs++; $display("FAIL cap_en_drop: got n=%0d short=%b busy=%b want n=1 short=0 busy=0",
                             g0_done - d0, g0_short, busy0);
        end
    endtask

    task automatic test_reset_mid;
        int b0, d0;
        b0 = g0_addr.size(); d0 = g0_done;
        start_capture(1'b1);
        vsync = 1'b0; tick; tick; tick;
        href = 1'b1;
        data = 8'h11; tick; data = 8'h22; tick; data = 8'h33; tick;
        data = 8'h44; reset = 1'b1; tick;
        vecs++;
        if (we0 !== 1'b0 || busy0 !== 1'b0 || fd0 !== 1'b0) begin
            errs++; $display("FAIL reset_mid_now: got we=%b busy=%b done=%b want 0 0 0", we0, busy0, fd0);
        end
        reset = 1'b0;
        data = 8'h55; tick; data = 8'h66; tick;
        href = 1'b0; repeat (2) tick;
        vsync = 1'b1; repeat (6) tick;
        vecs++;
        if (g0_addr.size() - b0 != 1 || g0_done - d0 != 0 || busy0 !== 1'b0) begin
            errs++; $display("FAIL reset_mid_after: got w=%0d n=%0d busy=%b want w=1 n=0 busy=0",
                             g0_addr.size() - b0, g0_done - d0, busy0);
        end
    endtask

    task automatic test_random;
        int b0, b1, d0, d1;
        for (int f = 0; f < 8; f++) begin
            byte_swap = 1'($urandom);
            n_lines = $urandom_range(1, 5);
            for (int l = 0; l < n_lines; l++)
                line_len[l] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 8;
            b0 = g0_addr.size(); b1 = g1_addr.size(); d0 = g0_done; d1 = g1_done;
            start_capture(1'b1);
            drive_frame(0);
            build_expected(4, 2, 0);
            vecs++;
            if (g0_addr.size() - b0 != exp_addr.size() || g0_done - d0 != 1 || g0_short !== exp_short || se0 !== exp_err) begin
                errs++; $display("FAIL rand%0d_dut0: got w=%0d n=%0d short=%b err=%b want w=%0d n=1 short=%b err=%b", f,
                                 g0_addr.size() - b0, g0_done - d0, g0_short, se0, exp_addr.size(), exp_short, exp_err);
            end
            for (int i = 0; i < exp_addr.size() && b0 + i < g0_addr.size(); i++) begin
                vecs++;
                if (g0_addr[b0+i] !== exp_addr[i] || g0_data[b0+i] !== exp_data[i] || g0_cyc[b0+i] !== exp_cyc[i]) begin
                    errs++; $display("FAIL rand%0d_dut0_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", f, i,
                                     g0_addr[b0+i], g0_data[b0+i], g0_cyc[b0+i], exp_addr[i], exp_data[i], exp_cyc[i]);
                end
            end
            build_expected(4, 4, 1);
            vecs++;
            if (g1_addr.size() - b1 != exp_addr.size() || g1_done - d1 != 1 || g1_short !== exp_short || se1 !== exp_err) begin
                errs++; $display("FAIL rand%0d_dut1: got w=%0d n=%0d short=%b err=%b want w=%0d n=1 short=%b err=%b", f,
                                 g1_addr.size() - b1, g1_done - d1, g1_short, se1, exp_addr.size(), exp_short, exp_err);
            end
            for (int i = 0; i < exp_addr.size() && b1 + i < g1_addr.size(); i++) begin
                vecs++;
                if (g1_addr[b1+i] !== exp_addr[i] || g1_data[b1+i] !== exp_data[i] || g1_cyc[b1+i] !== exp_cyc[i]) begin
                    errs++; $display("FAIL rand%0d_dut1_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", f, i,
                                     g1_addr[b1+i], g1_data[b1+i], g1_cyc[b1+i], exp_addr[i], exp_data[i], exp_cyc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_scale;
        test_swap;
        test_sync_err;
        test_short_frame;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter SRC_W, default 640, meaning source pixels per line (2 bytes per pixel).
REQ-002 Parameter SRC_H, default 480, meaning source lines per frame.
REQ-003 Parameter SCALE_SHIFT, default 1, meaning decimation factor 2^SCALE_SHIFT in x and y (legal 0..3).
REQ-004 Parameter ADDR_W, default 17, meaning write-address width; SHALL hold (SRC_W>>S)*(SRC_H>>S)-1.
REQ-005 clk  in  1  capture clock; camera inputs sampled on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 href  in  1  camera line-valid.
REQ-008 vsync  in  1  camera frame sync; high between frames.
REQ-009 data  in  8  camera byte, MSB byte of each pixel first.
REQ-010 cap_en  in  1  capture enable; sampled only in IDLE.
REQ-011 single_shot  in  1  1 = capture one frame then stop; 0 = continuous.
REQ-012 byte_swap  in  1  1 = first byte goes to wData[7:0].
REQ-013 we  out  1  memory write strobe, one cycle per stored pixel.
REQ-014 wAddr  out  ADDR_W  memory write address.
REQ-015 wData  out  16  assembled pixel.
REQ-016 busy  out  1  high in WAIT_SOF or ACTIVE.
REQ-017 frame_done  out  1  one-cycle pulse at end of each captured frame.
REQ-018 frame_short  out  1  valid with frame_done; 1 if fewer than SRC_H lines received.
REQ-019 sync_err  out  1  sticky; odd byte count in a line or line longer than SRC_W pixels.

Function
REQ-020 FSM states IDLE, WAIT_SOF, ACTIVE, DONE SHALL be implemented.
REQ-021 IDLE -> WAIT_SOF when cap_en=1.
REQ-022 WAIT_SOF -> ACTIVE on vsync falling edge (registered vsync=1, current vsync=0); href ignored in WAIT_SOF.
REQ-023 Entering ACTIVE SHALL clear x pixel counter, y line counter, byte phase and wAddr to 0.
REQ-024 In ACTIVE with href=1 each cycle SHALL capture one byte; byte phase toggles; second byte completes a pixel and increments x.
REQ-025 href falling edge SHALL increment y, clear x and byte phase; odd phase at that edge SHALL set sync_err.
REQ-026 A completed pixel SHALL be written iff x[S-1:0]==0, y[S-1:0]==0, x<SRC_W, y<SRC_H (S=SCALE_SHIFT; S=0 means every pixel).
REQ-027 Pixel with x>=SRC_W SHALL be dropped and set sync_err; lines with y>=SRC_H SHALL be dropped without error.
REQ-028 wAddr SHALL be a running counter incremented after each write, no multiplier; stops at max, never wraps within a frame.
REQ-029 we, wAddr, wData SHALL be registered; we high exactly the cycle after the second byte of a stored pixel is sampled, wAddr/wData stable in that cycle.
REQ-030 we SHALL be 0 on every cycle with no stored pixel completing.
REQ-031 vsync rising edge in ACTIVE SHALL end the frame -> DONE; frame_short = (y < SRC_H) latched.
REQ-032 DONE SHALL pulse frame_done one cycle, then -> IDLE if single_shot=1 else ACTIVE-via-WAIT_SOF.
REQ-033 cap_en=0 while busy SHALL not abort; frame completes, then IDLE.
REQ-034 Byte completing a pixel coincident with href fall SHALL be counted as the second byte of that pixel before line end processing.
REQ-035 sync_err SHALL clear only on reset or entry to WAIT_SOF from IDLE.

Reset
REQ-036 reset SHALL force IDLE; we=0, wAddr=0, wData=0, busy=0, frame_done=0, frame_short=0, sync_err=0, all counters 0.
REQ-037 reset mid-frame SHALL discard the frame with no frame_done and no further writes.

Verification
REQ-038 SRC_W=4,SRC_H=2,S=0, cap_en=1,single_shot=1, full frame bytes 00..0F -> 8 writes, addr 0..7, wData 0x0001,0x0203.., one frame_done, frame_short=0, busy drops, IDLE.
REQ-039 SRC_W=4,SRC_H=4,S=1, full frame -> 4 writes only for (x,y) in {0,2}x{0,2}, addr 0..3.
REQ-040 byte_swap=1, bytes AA,55 -> wData=0x55AA.
REQ-041 line with 7 bytes -> sync_err=1 sticky; next line still aligned from byte phase 0.
REQ-042 vsync rises after 1 of 2 lines -> frame_done with frame_short=1; single_shot=0 -> next frame restarts at addr 0.
REQ-043 reset asserted mid-line -> we=0 next cycle, IDLE, no frame_done.
